// File: rtl/data_mem_arb.sv
// Two-port arbiter/sequencer for the single data memory port: one outstanding access, fixed read latency.
// Define DATA_MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module data_mem_arb #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned DATA_W      = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [1:0]        p0_byte_en_i,
    input  logic              p0_wr_i,
    input  logic [DATA_W-1:0] p0_wr_data_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [1:0]        p1_byte_en_i,
    input  logic              p1_wr_i,
    input  logic [DATA_W-1:0] p1_wr_data_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              data_mem_req_o,
    output logic [ADDR_W-1:0] data_mem_addr_o,
    output logic [1:0]        data_mem_byte_en_o,
    output logic              data_mem_wr_o,
    output logic [DATA_W-1:0] data_mem_wr_data_o,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_lat_cnt;
    logic               r_owner;
    logic [ADDR_W-1:0]  r_addr;
    logic [1:0]         r_byte_en;
    logic               r_wr;
    logic [DATA_W-1:0]  r_wr_data;

    logic               w_pick1;
    logic               w_idle;
    logic               w_resp;

    // Arbitration: w_pick1 selects port 1 for the grant.
`ifdef DATA_MEM_ARB_RR_EN
    logic               r_last;
    assign w_pick1 = p1_req_i && (!p0_req_i || !r_last);
`else
    assign w_pick1 = p1_req_i && !p0_req_i;
`endif

    assign w_idle   = (r_state == S_IDLE) && !reset;
    assign w_resp   = (r_state == S_RESP) && !reset;
    assign p0_gnt_o = w_idle && p0_req_i && !w_pick1;
    assign p1_gnt_o = w_idle && w_pick1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= '0;
            r_owner   <= 1'b0;
            r_addr    <= '0;
            r_byte_en <= '0;
            r_wr      <= 1'b0;
            r_wr_data <= '0;
`ifdef DATA_MEM_ARB_RR_EN
            r_last    <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (p0_req_i || p1_req_i) begin
                        r_owner   <= w_pick1;
                        r_addr    <= w_pick1 ? p1_addr_i    : p0_addr_i;
                        r_byte_en <= w_pick1 ? p1_byte_en_i : p0_byte_en_i;
                        r_wr      <= w_pick1 ? p1_wr_i      : p0_wr_i;
                        r_wr_data <= w_pick1 ? p1_wr_data_i : p0_wr_data_i;
`ifdef DATA_MEM_ARB_RR_EN
                        r_last    <= w_pick1;
`endif
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (MEM_LATENCY == 1) begin
                        r_state <= S_RESP;
                    end else begin
                        r_lat_cnt <= CNT_W'(MEM_LATENCY - 1);
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Entered with a count >= 1, so the decrement stops at zero.
                    r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    if (r_lat_cnt == CNT_W'(1)) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low while reset is asserted.
    assign data_mem_req_o     = (r_state == S_ACCESS) && !reset;
    assign data_mem_addr_o    = reset ? '0 : r_addr;
    assign data_mem_byte_en_o = reset ? '0 : r_byte_en;
    assign data_mem_wr_o      = r_wr && !reset;
    assign data_mem_wr_data_o = reset ? '0 : r_wr_data;
    assign busy_o             = (r_state != S_IDLE) && !reset;

    assign p0_rvalid_o = w_resp && !r_owner;
    assign p1_rvalid_o = w_resp && r_owner;
    assign p0_rdata_o  = (w_resp && !r_owner && !r_wr) ? mem_rd_data_i : '0;
    assign p1_rdata_o  = (w_resp && r_owner && !r_wr) ? mem_rd_data_i : '0;

endmodule

// File: tb/tb_data_mem_arb.sv
// Directed bench for data_mem_arb: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3, shared stimulus.
module tb_data_mem_arb;

    localparam int unsigned W = 19;
    localparam logic [1:0] BE_B = 2'd0;
    localparam logic [1:0] BE_H = 2'd1;
    localparam logic [1:0] BE_W = 2'd2;

    typedef struct packed {
        logic         rst;
        logic         r0;
        logic [W-1:0] a0;
        logic [1:0]   b0;
        logic         w0;
        logic [W-1:0] d0;
        logic         r1;
        logic [W-1:0] a1;
        logic [1:0]   b1;
        logic         w1;
        logic [W-1:0] d1;
        logic [W-1:0] mrd;
    } in_t;

    typedef struct packed {
        logic         g0;
        logic         g1;
        logic         v0;
        logic         v1;
        logic [W-1:0] rd0;
        logic [W-1:0] rd1;
        logic         mreq;
        logic [W-1:0] maddr;
        logic [1:0]   mbe;
        logic         mwr;
        logic [W-1:0] mwd;
        logic         busy;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         p0_req, p0_wr, p1_req, p1_wr;
    logic [W-1:0] p0_addr, p0_wd, p1_addr, p1_wd, mem_rdata;
    logic [1:0]   p0_be, p1_be;

    logic         a_g0, a_g1, a_v0, a_v1, a_mreq, a_mwr, a_busy;
    logic [W-1:0] a_rd0, a_rd1, a_maddr, a_mwd;
    logic [1:0]   a_mbe;
    logic         b_g0, b_g1, b_v0, b_v1, b_mreq, b_mwr, b_busy;
    logic [W-1:0] b_rd0, b_rd1, b_maddr, b_mwd;
    logic [1:0]   b_mbe;
    out_t         a_o, b_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_arb #(.MEM_LATENCY(1), .ADDR_W(W), .DATA_W(W)) u_l1 (
        .clk(clk), .reset(rst),
        .p0_req_i(p0_req), .p0_addr_i(p0_addr), .p0_byte_en_i(p0_be), .p0_wr_i(p0_wr),
        .p0_wr_data_i(p0_wd), .p0_gnt_o(a_g0), .p0_rvalid_o(a_v0), .p0_rdata_o(a_rd0),
        .p1_req_i(p1_req), .p1_addr_i(p1_addr), .p1_byte_en_i(p1_be), .p1_wr_i(p1_wr),
        .p1_wr_data_i(p1_wd), .p1_gnt_o(a_g1), .p1_rvalid_o(a_v1), .p1_rdata_o(a_rd1),
        .data_mem_req_o(a_mreq), .data_mem_addr_o(a_maddr), .data_mem_byte_en_o(a_mbe),
        .data_mem_wr_o(a_mwr), .data_mem_wr_data_o(a_mwd), .mem_rd_data_i(mem_rdata),
        .busy_o(a_busy)
    );

    data_mem_arb #(.MEM_LATENCY(3), .ADDR_W(W), .DATA_W(W)) u_l3 (
        .clk(clk), .reset(rst),
        .p0_req_i(p0_req), .p0_addr_i(p0_addr), .p0_byte_en_i(p0_be), .p0_wr_i(p0_wr),
        .p0_wr_data_i(p0_wd), .p0_gnt_o(b_g0), .p0_rvalid_o(b_v0), .p0_rdata_o(b_rd0),
        .p1_req_i(p1_req), .p1_addr_i(p1_addr), .p1_byte_en_i(p1_be), .p1_wr_i(p1_wr),
        .p1_wr_data_i(p1_wd), .p1_gnt_o(b_g1), .p1_rvalid_o(b_v1), .p1_rdata_o(b_rd1),
        .data_mem_req_o(b_mreq), .data_mem_addr_o(b_maddr), .data_mem_byte_en_o(b_mbe),
        .data_mem_wr_o(b_mwr), .data_mem_wr_data_o(b_mwd), .mem_rd_data_i(mem_rdata),
        .busy_o(b_busy)
    );

    assign a_o = {a_g0, a_g1, a_v0, a_v1, a_rd0, a_rd1, a_mreq, a_maddr, a_mbe, a_mwr, a_mwd, a_busy};
    assign b_o = {b_g0, b_g1, b_v0, b_v1, b_rd0, b_rd1, b_mreq, b_maddr, b_mbe, b_mwr, b_mwd, b_busy};

    function automatic in_t mk_i(logic rs, logic r0, logic [W-1:0] a0, logic [1:0] b0, logic w0,
                                 logic [W-1:0] d0, logic r1, logic [W-1:0] a1, logic [1:0] b1,
                                 logic w1, logic [W-1:0] d1, logic [W-1:0] mrd);
        return {rs, r0, a0, b0, w0, d0, r1, a1, b1, w1, d1, mrd};
    endfunction

    function automatic out_t mk_o(logic g0, logic g1, logic v0, logic v1, logic [W-1:0] rd0,
                                  logic [W-1:0] rd1, logic mreq, logic [W-1:0] maddr,
                                  logic [1:0] mbe, logic mwr, logic [W-1:0] mwd, logic busy);
        return {g0, g1, v0, v1, rd0, rd1, mreq, maddr, mbe, mwr, mwd, busy};
    endfunction

    task automatic apply(input in_t v);
        rst = v.rst;
        p0_req = v.r0; p0_addr = v.a0; p0_be = v.b0; p0_wr = v.w0; p0_wd = v.d0;
        p1_req = v.r1; p1_addr = v.a1; p1_be = v.b1; p1_wr = v.w1; p1_wd = v.d1;
        mem_rdata = v.mrd;
    endtask

    task automatic check(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (g0 g1 v0 v1 rd0 rd1 mreq maddr mbe mwr mwd busy)",
                     name, got, exp);
        end
    endtask

    task automatic check2(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    vec_t         vecs[19];
    out_t         e;
    logic [1:0]   eg;

    initial begin
        // Single-cycle records for the MEM_LATENCY=1 instance.
        vecs[0]  = {mk_i(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = {mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = {mk_i(0, 1, 'h100, BE_W, 0, 0, 0, 0, 0, 0, 0, 0), mk_o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = {mk_i(0, 0, 'h100, BE_W, 0, 0, 0, 0, 0, 0, 0, 0), mk_o(0, 0, 0, 0, 0, 0, 1, 'h100, BE_W, 0, 0, 1)};
        vecs[4]  = {mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h5A5A5), mk_o(0, 0, 1, 0, 'h5A5A5, 0, 0, 'h100, BE_W, 0, 0, 1)};
        vecs[5]  = {mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h5A5A5), mk_o(0, 0, 0, 0, 0, 0, 0, 'h100, BE_W, 0, 0, 0)};
        vecs[6]  = {mk_i(0, 0, 0, 0, 0, 0, 1, 'h42, BE_H, 1, 'h7FFFF, 0), mk_o(0, 1, 0, 0, 0, 0, 0, 'h100, BE_W, 0, 0, 0)};
        vecs[7]  = {mk_i(0, 0, 0, 0, 0, 0, 0, 'h42, BE_H, 1, 'h7FFFF, 0), mk_o(0, 0, 0, 0, 0, 0, 1, 'h42, BE_H, 1, 'h7FFFF, 1)};
        vecs[8]  = {mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h11111), mk_o(0, 0, 0, 1, 0, 0, 0, 'h42, BE_H, 1, 'h7FFFF, 1)};
        vecs[9]  = {mk_i(0, 1, 'h200, BE_W, 0, 'h2AAAA, 0, 0, 0, 0, 0, 0), mk_o(1, 0, 0, 0, 0, 0, 0, 'h42, BE_H, 1, 'h7FFFF, 0)};
        vecs[10] = {mk_i(0, 0, 0, 0, 0, 0, 1, 'h300, BE_B, 0, 0, 0), mk_o(0, 0, 0, 0, 0, 0, 1, 'h200, BE_W, 0, 'h2AAAA, 1)};
        vecs[11] = {mk_i(0, 0, 0, 0, 0, 0, 1, 'h300, BE_B, 0, 0, 'h0ABCD), mk_o(0, 0, 1, 0, 'h0ABCD, 0, 0, 'h200, BE_W, 0, 'h2AAAA, 1)};
        vecs[12] = {mk_i(0, 0, 0, 0, 0, 0, 1, 'h300, BE_B, 0, 0, 0), mk_o(0, 1, 0, 0, 0, 0, 0, 'h200, BE_W, 0, 'h2AAAA, 0)};
        vecs[13] = {mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_o(0, 0, 0, 0, 0, 0, 1, 'h300, BE_B, 0, 0, 1)};
        vecs[14] = {mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h6789A), mk_o(0, 0, 0, 1, 0, 'h6789A, 0, 'h300, BE_B, 0, 0, 1)};
        vecs[15] = {mk_i(0, 1, 'h400, BE_W, 0, 0, 1, 'h500, BE_H, 1, 'h1F00F, 0), mk_o(1, 0, 0, 0, 0, 0, 0, 'h300, BE_B, 0, 0, 0)};
        vecs[16] = {mk_i(0, 0, 0, 0, 0, 0, 0, 'h500, BE_H, 1, 'h1F00F, 0), mk_o(0, 0, 0, 0, 0, 0, 1, 'h400, BE_W, 0, 0, 1)};
        vecs[17] = {mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h33333), mk_o(0, 0, 1, 0, 'h33333, 0, 0, 'h400, BE_W, 0, 0, 1)};
        vecs[18] = {mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mk_o(0, 0, 0, 0, 0, 0, 0, 'h400, BE_W, 0, 0, 0)};

        apply(mk_i(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            apply(vecs[i].i);
            #1;
            check($sformatf("vec%0d", i), a_o, vecs[i].o);
        end

        // Both ports requesting continuously (MEM_LATENCY=1).
        @(negedge clk);
        apply(mk_i(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) apply(mk_i(0, 1, 'h10, BE_W, 0, 0, 1, 'h20, BE_W, 0, 0, 0));
            #1;
            eg = 2'b00;
            if (k % 3 == 0) begin
`ifdef DATA_MEM_ARB_RR_EN
                eg = ((k / 3) % 2 == 1) ? 2'b01 : 2'b10;
`else
                eg = 2'b10;
`endif
            end
            check2($sformatf("tie_gnt%0d", k), {a_g0, a_g1}, eg);
        end

        // MEM_LATENCY=3 read: data only valid at A+3.
        @(negedge clk);
        apply(mk_i(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            apply(mk_i(0, k == 0, 'h123, BE_W, 0, 0, 0, 0, 0, 0, 0, (k == 4) ? W'('h12345) : W'('h0DEAD)));
            #1;
            e = mk_o(k == 0, 0, k == 4, 0, (k == 4) ? W'('h12345) : W'(0), 0, k == 1,
                     (k >= 1) ? W'('h123) : W'(0), (k >= 1) ? BE_W : 2'd0, 0, 0, (k >= 1) && (k <= 4));
            check($sformatf("lat3_k%0d", k), b_o, e);
        end

        // MEM_LATENCY=3: reset in WAIT aborts, pending p1 is granted right after.
        @(negedge clk);
        apply(mk_i(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            apply(mk_i(k == 3, k == 0, 'h77, BE_W, 0, 0, (k == 3) || (k == 4), 'h88, BE_H, 0, 0,
                       (k == 8) ? W'('h44444) : W'('h0BEEF)));
            #1;
            case (k)
                0:       e = mk_o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                1:       e = mk_o(0, 0, 0, 0, 0, 0, 1, 'h77, BE_W, 0, 0, 1);
                2:       e = mk_o(0, 0, 0, 0, 0, 0, 0, 'h77, BE_W, 0, 0, 1);
                3:       e = mk_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                4:       e = mk_o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                5:       e = mk_o(0, 0, 0, 0, 0, 0, 1, 'h88, BE_H, 0, 0, 1);
                8:       e = mk_o(0, 0, 0, 1, 0, 'h44444, 0, 'h88, BE_H, 0, 0, 1);
                default: e = mk_o(0, 0, 0, 0, 0, 0, 0, 'h88, BE_H, 0, 0, 1);
            endcase
            check($sformatf("rstwait_k%0d", k), b_o, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
